line_window_gen: RTL and testbench
==================================

# line_window_gen

Parametrised sliding-window generator for the convolution datapath. It takes a raster-ordered feature-map stream carrying all channels in parallel. It emits one KSIZE×KSIZE window per channel per output position, with selectable stride and optional zero padding. Upstream stalls are handled through a valid/ready handshake. It sits between the activation buffer and the PE array, and replaces the fixed 3×3, stride-1 window wrapper.

## Interface
- FM_DEPTH, 64, channels processed in parallel
- FM_WIDTH, 56, input feature-map columns
- FM_HEIGHT, 56, input feature-map rows
- KSIZE, 3, window edge; odd, 3 ≤ KSIZE ≤ min(FM_WIDTH, FM_HEIGHT)
- DATA_W, 16, signed sample width
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- verticle_sync  in  1  frame start; one-cycle pulse
- mode_in  in  1  stride select, sampled with verticle_sync: 0 = stride 1, 1 = stride 2
- data_in_valid  in  1  data_in holds an input pixel
- data_in_ready  out  1  block consumes data_in this cycle if valid
- data_in  in  [FM_DEPTH-1:0][DATA_W-1:0]  one pixel, all channels
- data_out_valid  out  1  data_out holds a window
- data_out  out  [FM_DEPTH-1:0][KSIZE*KSIZE-1:0][DATA_W-1:0]  windows; tap i*KSIZE+j is row i, column j from top-left
- vs_next  out  1  pulse coincident with the last window of a frame

## Operation
- P = (KSIZE-1)/2 with padding compiled in, else 0. The block walks a virtual grid of GH = FM_HEIGHT+2P rows by GW = FM_WIDTH+2P columns in raster order, using row/col counters.
- Grid positions:
  - A pad position (row<P, row≥P+FM_HEIGHT, col<P or col≥P+FM_WIDTH) inserts zero for all channels and advances unconditionally.
  - An interior position advances only when data_in_valid && data_in_ready.
- States:
  - IDLE: ready=0, counters held. verticle_sync → RUN, counters cleared, stride latched from mode_in.
  - RUN: data_in_ready = (current position is interior). After the advance at (GH-1, GW-1) → IDLE.
  - verticle_sync in RUN aborts the frame: any advance that cycle is discarded, counters clear, stride is re-latched, and the block stays in RUN. No vs_next is produced for the aborted frame.
- Storage:
  - KSIZE-1 line buffers of GW entries × FM_DEPTH×DATA_W, written on every advance.
  - KSIZE×KSIZE shift window per channel.
- A window is complete on an advance at (r, c) when all of the following hold:
  - r ≥ KSIZE-1 and c ≥ KSIZE-1
  - (r-KSIZE+1) % S == 0
  - (c-KSIZE+1) % S == 0
- Output count per frame is ((GH-KSIZE)/S+1) × ((GW-KSIZE)/S+1), using floor division.
- vs_next pulses with the final window of a completed frame.
- Data is passed unmodified; there is no arithmetic on samples.
- data_in_valid while ready=0 is ignored. Upstream holds the pixel.

## Timing
- Reset values: data_out_valid=0, vs_next=0, data_in_ready=0, data_out all zero, state IDLE, counters zero.
- Window latency: data_out_valid and data_out are registered and appear 1 cycle after the completing advance.
- data_out holds its value until the next window.
- data_in_ready is a registered-state decode. It never depends combinationally on data_in_valid.
- Throughput is at most one advance per cycle. Pad insertion costs 1 cycle per pad position.
- verticle_sync in the cycle data_out_valid is high for the last window: the window and vs_next are still emitted, and the new frame starts.
- Reset mid-frame: all outputs go to reset values immediately. Line-buffer contents are don't-care.

## Configuration
- WINGEN_ZERO_PAD_EN defined: P=(KSIZE-1)/2 ("same" padding). Output is FM_HEIGHT×FM_WIDTH at stride 1, and data_in_ready drops during pad positions.
- WINGEN_ZERO_PAD_EN undefined: P=0 ("valid" only). The grid equals the input, and data_in_ready=1 throughout RUN.

## Test plan
Parameters for all scenarios: FM_WIDTH=FM_HEIGHT=4, KSIZE=3, FM_DEPTH=2, pixel (r,c) value = 4r+c.

1. Pad on, mode 0, continuous valid:
   - 16 windows.
   - First window taps = {0,0,0, 0,0,1, 0,4,5}.
   - Last window = {10,11,0, 14,15,0, 0,0,0}.
   - vs_next is high with the 16th data_out_valid.
2. Pad on, mode 1: 4 windows. The second window = {0,0,0, 1,2,3, 5,6,7}. vs_next is high with the 4th window.
3. Pad on, valid every 8th cycle:
   - Window sequence identical to scenario 1.
   - data_in_ready low for the first 7 cycles after verticle_sync.
4. verticle_sync after 7 accepted pixels, then a full frame:
   - No vs_next for the aborted frame.
   - Exactly 16 windows, identical to scenario 1.
5. rstn low mid-frame: all outputs 0 and ready 0. Input is ignored until the next verticle_sync, after which the full frame is correct.
6. Pad off, mode 0: 4 windows. The first = {0,1,2, 4,5,6, 8,9,10}, and data_in_ready stays at 1 throughout RUN.

Source files
------------

// File: rtl/line_window_gen.sv
// line_window_gen
// Sliding KSIZE x KSIZE window generator for a raster-ordered, all-channels-
// parallel feature-map stream. It walks a virtual grid (the input plus optional
// zero border) and emits one window per channel at every stride-aligned position.
// Optional feature: define WINGEN_ZERO_PAD_EN for "same" zero padding of
// (KSIZE-1)/2 on every side. Leave it undefined for "valid"-only windows.
module line_window_gen #(
  parameter int FM_DEPTH  = 64,
  parameter int FM_WIDTH  = 56,
  parameter int FM_HEIGHT = 56,
  parameter int KSIZE     = 3,
  parameter int DATA_W    = 16
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          verticle_sync,
  input  logic                                          mode_in,
  input  logic                                          data_in_valid,
  output logic                                          data_in_ready,
  input  logic [FM_DEPTH-1:0][DATA_W-1:0]               data_in,
  output logic                                          data_out_valid,
  output logic [FM_DEPTH-1:0][KSIZE*KSIZE-1:0][DATA_W-1:0] data_out,
  output logic                                          vs_next
);

  localparam int KK = KSIZE * KSIZE;
`ifdef WINGEN_ZERO_PAD_EN
  localparam int PAD = (KSIZE - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int GW = FM_WIDTH + 2 * PAD;
  localparam int GH = FM_HEIGHT + 2 * PAD;
  localparam int CW = $clog2(GW);
  localparam int RW = $clog2(GH);

  localparam logic [CW-1:0] COL_LAST    = CW'(GW - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(GH - 1);
  localparam logic [CW-1:0] COL_FIRST   = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST   = RW'(KSIZE - 1);
  // Position of the bottom-right window when stepping by two
  localparam logic [CW-1:0] COL_LAST_S2 = CW'(KSIZE - 1 + 2 * ((GW - KSIZE) / 2));
  localparam logic [RW-1:0] ROW_LAST_S2 = RW'(KSIZE - 1 + 2 * ((GH - KSIZE) / 2));

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [KSIZE-2:0]      hcol_t;    // previous rows of one column, [0] newest
  typedef hcol_t [FM_DEPTH-1:0]     lb_word_t;
  typedef sample_t [KSIZE-1:0]      kcol_t;    // one window column, [0] top row

  typedef enum logic {IDLE, RUN} state_t;

  state_t                           state_q, state_d;
  logic [RW-1:0]                    row;
  logic [CW-1:0]                    col;
  logic                             stride2;
  logic                             interior;
  logic                             clear;
  logic                             adv_p0;
  logic                             at_end;
  logic                             row_phase_ok, col_phase_ok;
  logic                             win_done_p0, win_last_p0;

  sample_t [FM_DEPTH-1:0]           pix_p0;
  lb_word_t                         lb_mem [GW];
  lb_word_t                         lb_rd_p0, lb_wr_p0;
  kcol_t [FM_DEPTH-1:0]             new_col_p0;
  kcol_t [FM_DEPTH-1:0][KSIZE-2:0]  win_cols;   // [KSIZE-2] is the most recent column
  sample_t [FM_DEPTH-1:0][KK-1:0]   win_p0;

  // Interior test: pad positions lie in the zero border around the input
`ifdef WINGEN_ZERO_PAD_EN
  localparam logic [RW-1:0] ROW_LO = RW'(PAD);
  localparam logic [RW-1:0] ROW_HI = RW'(PAD + FM_HEIGHT);
  localparam logic [CW-1:0] COL_LO = CW'(PAD);
  localparam logic [CW-1:0] COL_HI = CW'(PAD + FM_WIDTH);
  assign interior = (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);
`else
  assign interior = 1'b1;
`endif

  // Ready is a pure decode of registered state, never of data_in_valid
  assign data_in_ready = (state_q == RUN) && interior;

  assign at_end = (row == ROW_LAST) && (col == COL_LAST);

  // KSIZE is odd, so (pos - KSIZE + 1) is even exactly when pos has the parity of KSIZE-1
  assign row_phase_ok = !stride2 || (row[0] == ROW_FIRST[0]);
  assign col_phase_ok = !stride2 || (col[0] == COL_FIRST[0]);

  assign win_done_p0 = adv_p0 && (row >= ROW_FIRST) && (col >= COL_FIRST)
                       && row_phase_ok && col_phase_ok;
  assign win_last_p0 = stride2 ? ((row == ROW_LAST_S2) && (col == COL_LAST_S2)) : at_end;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and advance decode; a sync in RUN restarts the frame and drops this cycle's advance
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    adv_p0  = 1'b0;
    case (state_q)
      IDLE: begin
        if (verticle_sync) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (verticle_sync) begin
          clear = 1'b1;
        end else if (!interior || (data_in_valid && data_in_ready)) begin
          adv_p0 = 1'b1;
          if (at_end) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grid position counters and the stride latched at frame start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row     <= '0;
      col     <= '0;
      stride2 <= 1'b0;
    end else if (clear) begin
      row     <= '0;
      col     <= '0;
      stride2 <= mode_in;
    end else if (adv_p0) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Assemble the incoming column and the complete window that this advance would form
  always_comb begin
    pix_p0     = interior ? data_in : '0;
    lb_rd_p0   = lb_mem[col];
    lb_wr_p0   = '0;
    new_col_p0 = '0;
    win_p0     = '0;
    for (int ch = 0; ch < FM_DEPTH; ch++) begin
      for (int i = 0; i < KSIZE - 1; i++) begin
        new_col_p0[ch][i] = lb_rd_p0[ch][KSIZE-2-i];
      end
      new_col_p0[ch][KSIZE-1] = pix_p0[ch];
      lb_wr_p0[ch][0] = pix_p0[ch];
      for (int k = 1; k < KSIZE - 1; k++) begin
        lb_wr_p0[ch][k] = lb_rd_p0[ch][k-1];
      end
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE - 1; j++) begin
          win_p0[ch][i*KSIZE+j] = win_cols[ch][j][i];
        end
        win_p0[ch][i*KSIZE+KSIZE-1] = new_col_p0[ch][i];
      end
    end
  end

  // Line buffers and column shift window update on every advance
  always_ff @(posedge clk) begin
    if (adv_p0) begin
      lb_mem[col] <= lb_wr_p0;
      for (int ch = 0; ch < FM_DEPTH; ch++) begin
        for (int j = 0; j < KSIZE - 2; j++) begin
          win_cols[ch][j] <= win_cols[ch][j+1];
        end
        win_cols[ch][KSIZE-2] <= new_col_p0[ch];
      end
    end
  end

  // ---- stage p0 -> p1: registered window output ----
  // Output register; data_out holds the last window until the next one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_valid <= 1'b0;
      vs_next        <= 1'b0;
      data_out       <= '0;
    end else begin
      data_out_valid <= win_done_p0;
      vs_next        <= win_done_p0 && win_last_p0;
      if (win_done_p0) begin
        data_out <= win_p0;
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Testbench for line_window_gen: 4x4 two-channel frames, randomized handshake,
// windows checked against a padded-grid reference model.
module tb_line_window_gen;
  localparam int FM_DEPTH  = 2;
  localparam int FM_WIDTH  = 4;
  localparam int FM_HEIGHT = 4;
  localparam int KSIZE     = 3;
  localparam int DATA_W    = 16;
  localparam int KK        = KSIZE * KSIZE;
`ifdef WINGEN_ZERO_PAD_EN
  localparam int PAD = (KSIZE - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int GW   = FM_WIDTH + 2 * PAD;
  localparam int GH   = FM_HEIGHT + 2 * PAD;
  localparam int NPIX = FM_WIDTH * FM_HEIGHT;

  typedef logic [FM_DEPTH-1:0][DATA_W-1:0]         pix_t;
  typedef logic [FM_DEPTH-1:0][KK-1:0][DATA_W-1:0] win_t;

`ifdef WINGEN_ZERO_PAD_EN
  int lit_first [KK] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
  int lit_last  [KK] = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
  int lit_s2    [KK] = '{0, 0, 0, 1, 2, 3, 5, 6, 7};
  localparam int S2_IDX = 1;
`else
  int lit_first [KK] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int lit_last  [KK] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int lit_s2    [KK] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  localparam int S2_IDX = 0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic verticle_sync = 1'b0;
  logic mode_in = 1'b0;
  logic data_in_valid = 1'b0;
  logic data_in_ready, data_out_valid, vs_next;
  pix_t data_in = '0;
  win_t data_out;

  pix_t img [NPIX];
  win_t exp_q[$];
  win_t got_q[$];
  bit   got_vs[$];
  int   stray_vs = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   first_ready;
  bit   ready_all;

  always #5 clk = ~clk;

  line_window_gen #(
    .FM_DEPTH(FM_DEPTH), .FM_WIDTH(FM_WIDTH), .FM_HEIGHT(FM_HEIGHT),
    .KSIZE(KSIZE), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rstn(rstn), .verticle_sync(verticle_sync), .mode_in(mode_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in(data_in),
    .data_out_valid(data_out_valid), .data_out(data_out), .vs_next(vs_next)
  );

  // Capture every emitted window on the falling edge
  always @(negedge clk) begin
    if (data_out_valid) begin
      got_q.push_back(data_out);
      got_vs.push_back(vs_next);
    end else if (vs_next) begin
      stray_vs++;
    end
  end

  task automatic fill_image(input bit rnd);
    for (int r = 0; r < FM_HEIGHT; r++)
      for (int c = 0; c < FM_WIDTH; c++) begin
        img[r*FM_WIDTH+c][0] = 16'(4 * r + c);
        img[r*FM_WIDTH+c][1] = rnd ? 16'($urandom) : 16'(100 + 4 * r + c);
      end
  endtask

  // Reference: every stride-aligned KxK window of the zero-bordered image, raster order
  task automatic build_model(input bit s2);
    int s;
    win_t w;
    s = s2 ? 2 : 1;
    exp_q.delete();
    for (int r0 = 0; r0 + KSIZE <= GH; r0 += s)
      for (int c0 = 0; c0 + KSIZE <= GW; c0 += s) begin
        w = '0;
        for (int ch = 0; ch < FM_DEPTH; ch++)
          for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++) begin
              int pr, pc;
              pr = r0 + i - PAD;
              pc = c0 + j - PAD;
              if (pr >= 0 && pr < FM_HEIGHT && pc >= 0 && pc < FM_WIDTH)
                w[ch][i*KSIZE+j] = img[pr*FM_WIDTH+pc][ch];
            end
        exp_q.push_back(w);
      end
  endtask

  task automatic clear_capture();
    got_q.delete();
    got_vs.delete();
  endtask

  // Starts a frame (called #1 after a rising edge) and feeds pixels.
  // period: 0 random valid, 1 continuous, n valid raised every n-th cycle and held.
  // stop_after >= 0 returns right after that many pixels were accepted.
  // chain waits only until the last window is on the output, then returns.
  task automatic send_frame(input bit s2, input int period, input int stop_after, input bit chain);
    int acc, cyc, target, k;
    bit v, rdy;
    acc = 0; cyc = 0; v = 1'b0;
    target = (stop_after >= 0) ? stop_after : NPIX;
    verticle_sync = 1'b1; mode_in = s2; data_in_valid = 1'b0;
    @(posedge clk); #1;
    verticle_sync = 1'b0; mode_in = 1'($urandom_range(0, 1));
    first_ready = -1; ready_all = 1'b1;
    while (acc < target && cyc < 4000) begin
      if (!v) v = (period == 0) ? ($urandom_range(0, 2) == 0) : ((cyc % period) == period - 1);
      data_in_valid = v;
      data_in = img[acc];
      rdy = data_in_ready;
      if (rdy && first_ready < 0) first_ready = cyc;
      if (!rdy) ready_all = 1'b0;
      @(posedge clk);
      if (v && rdy) begin acc++; v = 1'b0; end
      #1;
      cyc++;
    end
    data_in_valid = 1'b0;
    n_cmp++;
    if (acc !== target) begin
      n_bad++;
      $display("FAIL feed_timeout: accepted %0d pixels, required %0d", acc, target);
    end
    if (stop_after < 0) begin
      if (chain) begin
        k = 0;
        while (!(data_out_valid && vs_next) && k < 200) begin
          @(posedge clk); #1; k++;
        end
        n_cmp++;
        if (k >= 200) begin
          n_bad++;
          $display("FAIL last_window_timeout: waited %0d cycles, required < 200", k);
        end
      end else begin
        repeat (3 * GW + 4) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", data_out_valid); end
    n_cmp++; if (vs_next !== 1'b0) begin n_bad++; $display("FAIL reset_vs: got %b, required 0", vs_next); end
    n_cmp++; if (data_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b, required 0", data_in_ready); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data: got %h, required 0", data_out); end
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (data_in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b, required 0", data_in_ready); end
    data_in_valid = 1'b0;
  endtask

  task automatic test_stride1();
    win_t w;
    fill_image(1'b1);
    clear_capture();
    send_frame(1'b0, 1, -1, 1'b0);
    build_model(1'b0);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL s1_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
      n_cmp++; if (got_q[n] !== exp_q[n]) begin n_bad++; $display("FAIL s1_win[%0d]: got %h, required %h", n, got_q[n], exp_q[n]); end
      n_cmp++; if (got_vs[n] !== (n == exp_q.size() - 1)) begin n_bad++; $display("FAIL s1_vs[%0d]: got %b", n, got_vs[n]); end
    end
    if (got_q.size() > 0) begin
      w = got_q[0];
      for (int t = 0; t < KK; t++) begin
        n_cmp++; if (w[0][t] !== 16'(lit_first[t])) begin n_bad++; $display("FAIL s1_first_tap%0d: got %0d, required %0d", t, w[0][t], lit_first[t]); end
      end
      w = got_q[got_q.size()-1];
      for (int t = 0; t < KK; t++) begin
        n_cmp++; if (w[0][t] !== 16'(lit_last[t])) begin n_bad++; $display("FAIL s1_last_tap%0d: got %0d, required %0d", t, w[0][t], lit_last[t]); end
      end
    end
    n_cmp++; if (data_in_ready !== 1'b0) begin n_bad++; $display("FAIL s1_idle_ready: got %b, required 0", data_in_ready); end
  endtask

  task automatic test_stride2();
    win_t w;
    fill_image(1'b1);
    clear_capture();
    send_frame(1'b1, 1, -1, 1'b0);
    build_model(1'b1);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL s2_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
      n_cmp++; if (got_q[n] !== exp_q[n]) begin n_bad++; $display("FAIL s2_win[%0d]: got %h, required %h", n, got_q[n], exp_q[n]); end
      n_cmp++; if (got_vs[n] !== (n == exp_q.size() - 1)) begin n_bad++; $display("FAIL s2_vs[%0d]: got %b", n, got_vs[n]); end
    end
    if (got_q.size() > S2_IDX) begin
      w = got_q[S2_IDX];
      for (int t = 0; t < KK; t++) begin
        n_cmp++; if (w[0][t] !== 16'(lit_s2[t])) begin n_bad++; $display("FAIL s2_lit_tap%0d: got %0d, required %0d", t, w[0][t], lit_s2[t]); end
      end
    end
  endtask

  task automatic test_stall();
    bit exp_ra;
    fill_image(1'b0);
    clear_capture();
    send_frame(1'b0, 8, -1, 1'b0);
    build_model(1'b0);
    n_cmp++; if (first_ready !== PAD * GW + PAD) begin n_bad++; $display("FAIL stall_first_ready: got %0d, required %0d", first_ready, PAD * GW + PAD); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL stall8_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
      n_cmp++; if (got_q[n] !== exp_q[n]) begin n_bad++; $display("FAIL stall8_win[%0d]: got %h, required %h", n, got_q[n], exp_q[n]); end
    end
    for (int f = 0; f < 3; f++) begin
      fill_image(1'b1);
      clear_capture();
      send_frame(1'b0, 0, -1, 1'b0);
      build_model(1'b0);
      exp_ra = (PAD == 0);
      n_cmp++; if (ready_all !== exp_ra) begin n_bad++; $display("FAIL rnd_ready_all: got %b, required %b", ready_all, exp_ra); end
      n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
        n_cmp++; if (got_q[n] !== exp_q[n]) begin n_bad++; $display("FAIL rnd_win[%0d]: got %h, required %h", n, got_q[n], exp_q[n]); end
        n_cmp++; if (got_vs[n] !== (n == exp_q.size() - 1)) begin n_bad++; $display("FAIL rnd_vs[%0d]: got %b", n, got_vs[n]); end
      end
    end
  endtask

  task automatic test_abort();
    int nv;
    fill_image(1'b1);
    clear_capture();
    send_frame(1'b0, 1, 7, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    nv = 0;
    foreach (got_vs[n]) nv += int'(got_vs[n]);
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL abort_vs: got %0d vs_next pulses, required 0", nv); end
    clear_capture();
    send_frame(1'b0, 1, -1, 1'b0);
    build_model(1'b0);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL abort_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
      n_cmp++; if (got_q[n] !== exp_q[n]) begin n_bad++; $display("FAIL abort_win[%0d]: got %h, required %h", n, got_q[n], exp_q[n]); end
      n_cmp++; if (got_vs[n] !== (n == exp_q.size() - 1)) begin n_bad++; $display("FAIL abort_vs[%0d]: got %b", n, got_vs[n]); end
    end
  endtask

  task automatic test_back_to_back();
    int m;
    fill_image(1'b1);
    clear_capture();
    send_frame(1'b0, 1, -1, 1'b1);
    send_frame(1'b0, 1, -1, 1'b0);
    build_model(1'b0);
    m = exp_q.size();
    n_cmp++; if (got_q.size() !== 2 * m) begin n_bad++; $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), 2 * m); end
    for (int n = 0; n < got_q.size() && n < 2 * m; n++) begin
      n_cmp++; if (got_q[n] !== exp_q[n % m]) begin n_bad++; $display("FAIL b2b_win[%0d]: got %h, required %h", n, got_q[n], exp_q[n % m]); end
      n_cmp++; if (got_vs[n] !== ((n % m) == m - 1)) begin n_bad++; $display("FAIL b2b_vs[%0d]: got %b", n, got_vs[n]); end
    end
  endtask

  task automatic test_reset_mid();
    fill_image(1'b1);
    clear_capture();
    send_frame(1'b0, 1, 12, 1'b0);
    rstn = 1'b0;
    #1;
    clear_capture();
    n_cmp++; if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b, required 0", data_out_valid); end
    n_cmp++; if (vs_next !== 1'b0) begin n_bad++; $display("FAIL midrst_vs: got %b, required 0", vs_next); end
    n_cmp++; if (data_in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b, required 0", data_in_ready); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL midrst_data: got %h, required 0", data_out); end
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    data_in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (data_in_ready !== 1'b0) begin n_bad++; $display("FAIL postrst_ready[%0d]: got %b, required 0", k, data_in_ready); end
    end
    data_in_valid = 1'b0;
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL postrst_windows: got %0d, required 0", got_q.size()); end
    clear_capture();
    send_frame(1'b0, 1, -1, 1'b0);
    build_model(1'b0);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL midrst_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
      n_cmp++; if (got_q[n] !== exp_q[n]) begin n_bad++; $display("FAIL midrst_win[%0d]: got %h, required %h", n, got_q[n], exp_q[n]); end
    end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (stray_vs !== 0) begin n_bad++; $display("FAIL stray_vs: got %0d, required 0", stray_vs); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
